// File: rtl/reg_rename_table.sv
// Rename-stage register alias table: speculative and committed arch->phys maps, one rename and one commit per cycle.
// Rename and free outputs are registered (latency 1); rename_ready drops on flush or when a real dest meets an empty free list.
module reg_rename_table #(
  parameter int REG_FILE_ADDR_WIDTH = 7
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           rename_valid,
  output logic                           rename_ready,
  input  logic                           rd_write,
  input  logic [4:0]                     rd,
  input  logic [4:0]                     rs1,
  input  logic [4:0]                     rs2,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] free_reg_num,
  input  logic                           free_empty,
  output logic                           take_next_free,
  output logic                           renamed_valid,
  output logic [REG_FILE_ADDR_WIDTH-1:0] prs1,
  output logic [REG_FILE_ADDR_WIDTH-1:0] prs2,
  output logic [REG_FILE_ADDR_WIDTH-1:0] prd,
  output logic [REG_FILE_ADDR_WIDTH-1:0] old_prd,
  output logic                           prd_write,
  input  logic                           commit_valid,
  input  logic                           commit_rd_write,
  input  logic [4:0]                     commit_rd,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] commit_prd,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] commit_old_prd,
  input  logic                           flush,
  output logic                           reg_freed,
  output logic [REG_FILE_ADDR_WIDTH-1:0] freed_reg_num
);

  localparam int PW = REG_FILE_ADDR_WIDTH;

  logic [PW-1:0] r_spec_map   [32];
  logic [PW-1:0] r_commit_map [32];

  logic w_wr;
  logic w_ready;
  logic w_accept;
  logic w_take;
  logic w_commit;

  // x0 is hardwired: never renamed, never committed, so map entry 0 stays 0.
  assign w_wr     = rd_write && (rd != 5'd0);
  assign w_ready  = reset && !flush && (!w_wr || !free_empty);
  assign w_accept = rename_valid && w_ready;
  assign w_take   = w_accept && w_wr;
  assign w_commit = commit_valid && commit_rd_write && (commit_rd != 5'd0);

  assign rename_ready   = w_ready;
  assign take_next_free = w_take;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        r_spec_map[i]   <= PW'(i);
        r_commit_map[i] <= PW'(i);
      end
    end else begin
      if (w_commit) begin
        r_commit_map[commit_rd] <= commit_prd;
      end
      // Flush restores from the committed map, letting a same-cycle commit win.
      for (int i = 0; i < 32; i++) begin
        if (flush) begin
          r_spec_map[i] <= (w_commit && commit_rd == 5'(i)) ? commit_prd : r_commit_map[i];
        end else if (w_take && rd == 5'(i)) begin
          r_spec_map[i] <= free_reg_num;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      renamed_valid <= 1'b0;
      prs1          <= '0;
      prs2          <= '0;
      prd           <= '0;
      old_prd       <= '0;
      prd_write     <= 1'b0;
    end else begin
      renamed_valid <= w_accept;
      if (w_accept) begin
        prs1 <= r_spec_map[rs1];
        prs2 <= r_spec_map[rs2];
        if (w_wr) begin
          prd       <= free_reg_num;
          old_prd   <= r_spec_map[rd];
          prd_write <= 1'b1;
        end else begin
          prd       <= '0;
          old_prd   <= '0;
          prd_write <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reg_freed     <= 1'b0;
      freed_reg_num <= '0;
    end else begin
      reg_freed <= w_commit;
      if (w_commit) begin
        freed_reg_num <= commit_old_prd;
      end
    end
  end

endmodule

// File: tb/tb_reg_rename_table.sv
// Directed table-driven bench for reg_rename_table plus a mid-stream reset sequence.
module tb_reg_rename_table;

  logic       clock;
  logic       reset;
  logic       rename_valid;
  logic       rename_ready;
  logic       rd_write;
  logic [4:0] rd, rs1, rs2;
  logic [6:0] free_reg_num;
  logic       free_empty;
  logic       take_next_free;
  logic       renamed_valid;
  logic [6:0] prs1, prs2, prd, old_prd;
  logic       prd_write;
  logic       commit_valid;
  logic       commit_rd_write;
  logic [4:0] commit_rd;
  logic [6:0] commit_prd, commit_old_prd;
  logic       flush;
  logic       reg_freed;
  logic [6:0] freed_reg_num;

  int errors = 0;
  int checks = 0;

  reg_rename_table #(.REG_FILE_ADDR_WIDTH(7)) dut (
    .clock(clock), .reset(reset),
    .rename_valid(rename_valid), .rename_ready(rename_ready),
    .rd_write(rd_write), .rd(rd), .rs1(rs1), .rs2(rs2),
    .free_reg_num(free_reg_num), .free_empty(free_empty),
    .take_next_free(take_next_free), .renamed_valid(renamed_valid),
    .prs1(prs1), .prs2(prs2), .prd(prd), .old_prd(old_prd), .prd_write(prd_write),
    .commit_valid(commit_valid), .commit_rd_write(commit_rd_write),
    .commit_rd(commit_rd), .commit_prd(commit_prd), .commit_old_prd(commit_old_prd),
    .flush(flush), .reg_freed(reg_freed), .freed_reg_num(freed_reg_num)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int rv, rw, rd, rs1, rs2, free, fe;
    int cv, crw, crd, cprd, cold, fl;
    int e_rdy, e_take;
    int e_rvld, e_prs1, e_prs2, e_prd, e_old, e_pw;
    int e_freed, e_fnum;
  } vec_t;

  vec_t vecs[20];
  vec_t post[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    rename_valid = 0; rd_write = 0; rd = 0; rs1 = 0; rs2 = 0;
    free_reg_num = 0; free_empty = 0;
    commit_valid = 0; commit_rd_write = 0; commit_rd = 0;
    commit_prd = 0; commit_old_prd = 0; flush = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clock);
    rename_valid = v.rv[0]; rd_write = v.rw[0]; rd = v.rd[4:0];
    rs1 = v.rs1[4:0]; rs2 = v.rs2[4:0];
    free_reg_num = v.free[6:0]; free_empty = v.fe[0];
    commit_valid = v.cv[0]; commit_rd_write = v.crw[0]; commit_rd = v.crd[4:0];
    commit_prd = v.cprd[6:0]; commit_old_prd = v.cold[6:0]; flush = v.fl[0];
    #1;
    chk($sformatf("v%0d rename_ready", idx), rename_ready, v.e_rdy);
    chk($sformatf("v%0d take_next_free", idx), take_next_free, v.e_take);
    @(posedge clock);
    #1;
    chk($sformatf("v%0d renamed_valid", idx), renamed_valid, v.e_rvld);
    chk($sformatf("v%0d prs1", idx), prs1, v.e_prs1);
    chk($sformatf("v%0d prs2", idx), prs2, v.e_prs2);
    chk($sformatf("v%0d prd", idx), prd, v.e_prd);
    chk($sformatf("v%0d prd_write", idx), prd_write, v.e_pw);
    if (v.e_rvld != 0 && v.e_pw != 0)
      chk($sformatf("v%0d old_prd", idx), old_prd, v.e_old);
    chk($sformatf("v%0d reg_freed", idx), reg_freed, v.e_freed);
    if (v.e_freed != 0)
      chk($sformatf("v%0d freed_reg_num", idx), freed_reg_num, v.e_fnum);
  endtask

  initial begin
    //          rv rw rd rs1 rs2 free fe  cv crw crd cprd cold fl  rdy take rvld prs1 prs2 prd old pw fr fnum
    vecs[0]  = '{1, 0, 0,  7, 31,   0, 0,  0, 0, 0,  0,  0, 0,  1, 0,  1,  7, 31,  0,  0, 0, 0,  0};
    vecs[1]  = '{1, 1, 5,  0,  0,  32, 0,  0, 0, 0,  0,  0, 0,  1, 1,  1,  0,  0, 32,  5, 1, 0,  0};
    vecs[2]  = '{1, 0, 0,  5,  5,   0, 0,  0, 0, 0,  0,  0, 0,  1, 0,  1, 32, 32,  0,  0, 0, 0,  0};
    vecs[3]  = '{1, 1, 0,  1,  2,  40, 1,  0, 0, 0,  0,  0, 0,  1, 0,  1,  1,  2,  0,  0, 0, 0,  0};
    vecs[4]  = '{1, 1, 6,  1,  2,  33, 1,  0, 0, 0,  0,  0, 0,  0, 0,  0,  1,  2,  0,  0, 0, 0,  0};
    vecs[5]  = '{1, 1, 6,  1,  2,  33, 0,  0, 0, 0,  0,  0, 0,  1, 1,  1,  1,  2, 33,  6, 1, 0,  0};
    vecs[6]  = '{0, 0, 0,  0,  0,   0, 0,  1, 1, 5, 32,  5, 0,  1, 0,  0,  1,  2, 33,  0, 1, 1,  5};
    vecs[7]  = '{0, 0, 0,  0,  0,   0, 0,  0, 0, 0,  0,  0, 0,  1, 0,  0,  1,  2, 33,  0, 1, 0,  0};
    vecs[8]  = '{1, 1, 7,  0,  0,  34, 0,  0, 0, 0,  0,  0, 1,  0, 0,  0,  1,  2, 33,  0, 1, 0,  0};
    vecs[9]  = '{1, 0, 0,  6,  5,   0, 0,  0, 0, 0,  0,  0, 0,  1, 0,  1,  6, 32,  0,  0, 0, 0,  0};
    vecs[10] = '{1, 1, 6,  6,  0,  33, 0,  0, 0, 0,  0,  0, 0,  1, 1,  1,  6,  0, 33,  6, 1, 0,  0};
    vecs[11] = '{0, 0, 0,  0,  0,   0, 0,  1, 1, 6, 33,  6, 1,  0, 0,  0,  6,  0, 33,  0, 1, 1,  6};
    vecs[12] = '{1, 0, 0,  6,  5,   0, 0,  0, 0, 0,  0,  0, 0,  1, 0,  1, 33, 32,  0,  0, 0, 0,  0};
    vecs[13] = '{1, 1, 6,  6,  0,  35, 0,  1, 1, 6, 35, 33, 0,  1, 1,  1, 33,  0, 35, 33, 1, 1, 33};
    vecs[14] = '{0, 0, 0,  0,  0,   0, 0,  0, 0, 0,  0,  0, 1,  0, 0,  0, 33,  0, 35,  0, 1, 0,  0};
    vecs[15] = '{1, 0, 0,  6,  5,   0, 0,  0, 0, 0,  0,  0, 0,  1, 0,  1, 35, 32,  0,  0, 0, 0,  0};
    vecs[16] = '{0, 0, 0,  0,  0,   0, 0,  1, 0, 7, 50,  7, 0,  1, 0,  0, 35, 32,  0,  0, 0, 0,  0};
    vecs[17] = '{0, 0, 0,  0,  0,   0, 0,  1, 1, 0, 51,  0, 0,  1, 0,  0, 35, 32,  0,  0, 0, 0,  0};
    vecs[18] = '{0, 0, 0,  0,  0,   0, 0,  0, 0, 0,  0,  0, 1,  0, 0,  0, 35, 32,  0,  0, 0, 0,  0};
    vecs[19] = '{1, 0, 0,  7,  0,   0, 0,  0, 0, 0,  0,  0, 0,  1, 0,  1,  7,  0,  0,  0, 0, 0,  0};

    // After a mid-stream reset: flush must restore identity, then x9/x5 read back unrenamed.
    post[0]  = '{0, 0, 0,  0,  0,   0, 0,  0, 0, 0,  0,  0, 1,  0, 0,  0,  0,  0,  0,  0, 0, 0,  0};
    post[1]  = '{1, 0, 0,  9,  5,   0, 0,  0, 0, 0,  0,  0, 0,  1, 0,  1,  9,  5,  0,  0, 0, 0,  0};

    reset = 1'b0;
    idle();
    @(negedge clock);
    chk("reset renamed_valid", renamed_valid, 0);
    chk("reset prd_write", prd_write, 0);
    chk("reset reg_freed", reg_freed, 0);
    chk("reset prs1", prs1, 0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) run_vec(i, vecs[i]);

    // Rename x9 and commit x9 in flight, then pull reset mid-cycle.
    @(negedge clock);
    rename_valid = 1; rd_write = 1; rd = 9; rs1 = 9; rs2 = 9; free_reg_num = 60;
    commit_valid = 1; commit_rd_write = 1; commit_rd = 9; commit_prd = 61; commit_old_prd = 9;
    #1;
    chk("pre-reset take_next_free", take_next_free, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("in-reset rename_ready", rename_ready, 0);
    chk("in-reset take_next_free", take_next_free, 0);
    chk("in-reset renamed_valid", renamed_valid, 0);
    chk("in-reset prs1", prs1, 0);
    chk("in-reset prs2", prs2, 0);
    chk("in-reset prd", prd, 0);
    chk("in-reset old_prd", old_prd, 0);
    chk("in-reset prd_write", prd_write, 0);
    chk("in-reset reg_freed", reg_freed, 0);
    chk("in-reset freed_reg_num", freed_reg_num, 0);
    @(posedge clock);
    #1;
    chk("held-reset renamed_valid", renamed_valid, 0);
    chk("held-reset reg_freed", reg_freed, 0);
    @(negedge clock);
    idle();
    reset = 1'b1;

    for (int i = 0; i < 2; i++) run_vec(100 + i, post[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
